// File: rtl/param_univ_shift_reg.sv
// Universal WIDTH-bit shift/rotate register: load, logical shift, rotate, multi-step commands.
// One step per clock; busy while a multi-step command runs, one-cycle done pulse at completion.
module param_univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start_in,
   input  logic [2:0]       mode_in,
   input  logic [CNT_W-1:0] amount_in,
   input  logic [WIDTH-1:0] d_in,
   input  logic             serial_l_in,
   input  logic             serial_r_in,
   output logic [WIDTH-1:0] q_out,
   output logic             carry_out,
   output logic             busy_out,
   output logic             done_out
);

   typedef enum logic {IDLE, SHIFT} state_t;

   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHR  = 3'b010;
   localparam logic [2:0] M_SHL  = 3'b011;
   localparam logic [2:0] M_ROR  = 3'b100;
   localparam logic [2:0] M_ROL  = 3'b101;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] q_nxt, step_q;
   logic             carry_nxt, step_c, done_nxt;
   logic [2:0]       mode_q, mode_nxt, step_mode;
   logic [CNT_W-1:0] remain, remain_nxt;
   logic             is_step_mode;

   assign busy_out     = (state == SHIFT);
   assign step_mode    = (state == SHIFT) ? mode_q : mode_in;
   assign is_step_mode = (mode_in inside {M_SHR, M_SHL, M_ROR, M_ROL});

   // Single step of the selected operation applied to the current contents.
   always_comb begin
      step_q = q_out;
      step_c = carry_out;
      case (step_mode)
         M_SHR: begin step_q = {serial_l_in, q_out[WIDTH-1:1]}; step_c = q_out[0];       end
         M_SHL: begin step_q = {q_out[WIDTH-2:0], serial_r_in}; step_c = q_out[WIDTH-1]; end
         M_ROR: begin step_q = {q_out[0], q_out[WIDTH-1:1]};    step_c = q_out[0];       end
         M_ROL: begin step_q = {q_out[WIDTH-2:0], q_out[WIDTH-1]}; step_c = q_out[WIDTH-1]; end
         default: ;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      q_nxt      = q_out;
      carry_nxt  = carry_out;
      done_nxt   = 1'b0;
      mode_nxt   = mode_q;
      remain_nxt = remain;
      case (state)
         IDLE: begin
            if (start_in) begin
               if (mode_in == M_LOAD) begin
                  q_nxt    = d_in;
                  done_nxt = 1'b1;
               end else if (is_step_mode && (amount_in != '0)) begin
                  q_nxt      = step_q;
                  carry_nxt  = step_c;
                  mode_nxt   = mode_in;
                  remain_nxt = amount_in - 1'b1;
                  if (amount_in == CNT_W'(1)) done_nxt  = 1'b1;
                  else                        state_nxt = SHIFT;
               end else begin
                  done_nxt = 1'b1;
               end
            end
         end
         SHIFT: begin
            q_nxt      = step_q;
            carry_nxt  = step_c;
            remain_nxt = remain - 1'b1;
            // remain counts steps still owed including this one.
            if (remain == CNT_W'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state     <= IDLE;
         q_out     <= '0;
         carry_out <= 1'b0;
         done_out  <= 1'b0;
         mode_q    <= '0;
         remain    <= '0;
      end else begin
         state     <= state_nxt;
         q_out     <= q_nxt;
         carry_out <= carry_nxt;
         done_out  <= done_nxt;
         mode_q    <= mode_nxt;
         remain    <= remain_nxt;
      end
   end

endmodule

// File: tb/tb_param_univ_shift_reg.sv
// Bench for param_univ_shift_reg: directed scenarios plus random commands against a reference model.
module tb_param_univ_shift_reg;

   logic       clk = 1'b0;
   logic       reset_in = 1'b1;
   logic       start_in = 1'b0;
   logic [2:0] mode_in = '0;
   logic [3:0] amount_in = '0;
   logic [7:0] d_in = '0;
   logic       serial_l_in = 1'b0;
   logic       serial_r_in = 1'b0;
   logic [7:0] q_out;
   logic       carry_out, busy_out, done_out;

   int         n_chk = 0;
   int         n_fail = 0;
   logic [7:0] mq = '0;
   logic       mc = 1'b0;

   param_univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
      .clk(clk), .reset_in(reset_in), .start_in(start_in), .mode_in(mode_in),
      .amount_in(amount_in), .d_in(d_in), .serial_l_in(serial_l_in),
      .serial_r_in(serial_r_in), .q_out(q_out), .carry_out(carry_out),
      .busy_out(busy_out), .done_out(done_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command at the current negedge and check the whole handshake.
   task automatic run_cmd(input logic [2:0] m, input logic [3:0] k, input logic [7:0] d,
                          input logic sl, input logic sr, input bit junk, input bit gap);
      logic [7:0]  eq;
      logic        ec;
      logic [31:0] ext;
      int          lat, n, r;
      bit          seen;
      eq  = mq;
      ec  = mc;
      lat = 1;
      if (m == 3'd1) begin
         eq = d;
      end else if (m >= 3'd2 && m <= 3'd5 && k != 0) begin
         lat = k;
         case (m)
            3'd2: begin ext = {{24{sl}}, mq}; ec = ext[k-1]; eq = 8'(ext >> k); end
            3'd3: begin ext = {mq, {24{sr}}}; ec = ext[32-k]; ext = ext << k; eq = ext[31:24]; end
            3'd4: begin r = k % 8; ec = mq[(k-1) % 8]; ext = {16'd0, mq, mq} >> r; eq = ext[7:0]; end
            default: begin r = k % 8; ec = mq[7 - ((k-1) % 8)]; ext = {16'd0, mq, mq} << r; eq = ext[15:8]; end
         endcase
      end
      start_in = 1'b1; mode_in = m; amount_in = k; d_in = d;
      serial_l_in = sl; serial_r_in = sr;
      n = 0; seen = 0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         chk("busy", busy_out, (n < lat) ? 1 : 0);
         seen = done_out;
         if (!seen && junk) begin
            start_in  = 1'($urandom % 2);
            mode_in   = 3'($urandom % 8);
            amount_in = 4'($urandom % 16);
            d_in      = 8'($urandom);
         end else begin
            start_in = 1'b0;
         end
      end
      start_in = 1'b0;
      chk("latency", n, lat);
      chk("q", q_out, eq);
      chk("carry", carry_out, ec);
      mq = eq;
      mc = ec;
      if (gap) begin
         @(negedge clk);
         chk("done_width", done_out, 0);
         chk("q_hold", q_out, mq);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_q", q_out, 0);
      chk("rst_carry", carry_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_done", done_out, 0);
      reset_in = 1'b0;

      run_cmd(3'd1, 4'd0, 8'hA5, 0, 0, 0, 1);
      chk("load_a5", q_out, 8'hA5);
      run_cmd(3'd2, 4'd3, 8'h00, 1, 0, 0, 1);
      chk("shr3_q", q_out, 8'hF4);
      chk("shr3_c", carry_out, 1);
      run_cmd(3'd1, 4'd0, 8'hA5, 0, 0, 0, 0);
      run_cmd(3'd5, 4'd4, 8'h00, 0, 0, 0, 1);
      chk("rol4_q", q_out, 8'h5A);
      chk("rol4_c", carry_out, 0);
      run_cmd(3'd1, 4'd0, 8'hA5, 0, 0, 0, 0);
      run_cmd(3'd5, 4'd8, 8'h00, 0, 0, 0, 1);
      chk("rol8_q", q_out, 8'hA5);

      // Reset during the second cycle of a multi-step shift.
      start_in = 1'b1; mode_in = 3'd3; amount_in = 4'd5; serial_r_in = 1'b1;
      @(negedge clk);
      start_in = 1'b0;
      reset_in = 1'b1;
      @(negedge clk);
      reset_in = 1'b0;
      chk("mid_rst_q", q_out, 0);
      chk("mid_rst_busy", busy_out, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("mid_rst_nodone", done_out, 0);
      end
      mq = '0;
      mc = 1'b0;
      run_cmd(3'd1, 4'd0, 8'h3C, 0, 0, 0, 0);
      run_cmd(3'd4, 4'd6, 8'h00, 0, 0, 1, 1);
      run_cmd(3'd3, 4'd0, 8'hFF, 0, 1, 0, 1);

      for (int t = 0; t < 200; t++) begin
         run_cmd(3'($urandom % 8), 4'($urandom % 16), 8'($urandom),
                 1'($urandom % 2), 1'($urandom % 2), bit'($urandom % 2), bit'($urandom % 2));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
